// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor state encoding; the vending FSM reuses the codes.
package coin_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      QUALIFY,
      WAIT_RELEASE,
      REJECT,
      JAM
   } acc_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin-slot sensor inputs and classified-coin outputs between the slot and the vending FSM.
interface coin_acceptor_if;

   logic       sense5_raw;
   logic       sense10_raw;
   logic       inhibit;
   logic [1:0] coin;
   logic       reject_gate;
   logic       jam;
   logic [7:0] accepted_cnt;

   modport master (
      output sense5_raw, sense10_raw, inhibit,
      input  coin, reject_gate, jam, accepted_cnt
   );

   modport slave (
      input  sense5_raw, sense10_raw, inhibit,
      output coin, reject_gate, jam, accepted_cnt
   );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous level input, cleared by synchronous reset.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Synchronises and debounces the coin sensors, classifies each coin, and drives
// the reject chute and jam flag.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = 4,
   parameter int unsigned JAM_CYCLES    = 64,
   parameter int unsigned REJECT_CYCLES = 8
) (
   input logic            clk,
   input logic            rst,
   coin_acceptor_if.slave bus
);

   localparam int unsigned CntMax = (JAM_CYCLES > REJECT_CYCLES) ? JAM_CYCLES : REJECT_CYCLES;
   localparam int unsigned CW     = $clog2(CntMax + 1);

   localparam logic [CW-1:0] DebLast = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] JamLast = CW'(JAM_CYCLES - 1);
   localparam logic [CW-1:0] RejLast = CW'(REJECT_CYCLES - 1);

   logic s5, s10;

   acc_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] hi_q, hi_d;
   logic          is10_q, is10_d;
   logic [1:0]    coin_q, coin_d;
   logic          reject_q, reject_d;
   logic          jam_q, jam_d;
   logic [7:0]    acc_q, acc_d;
   logic          emit;
   logic          lat, oth, both_low;

   sync2 u_sync5 (.clk(clk), .rst(rst), .d_i(bus.sense5_raw), .q_o(s5));
   sync2 u_sync10 (.clk(clk), .rst(rst), .d_i(bus.sense10_raw), .q_o(s10));

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         is10_q   <= 1'b0;
         coin_q   <= COIN_NONE;
         reject_q <= 1'b0;
         jam_q    <= 1'b0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         is10_q   <= is10_d;
         coin_q   <= coin_d;
         reject_q <= reject_d;
         jam_q    <= jam_d;
         acc_q    <= acc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      is10_d   = is10_q;
      emit     = 1'b0;
      lat      = is10_q ? s10 : s5;
      oth      = is10_q ? s5 : s10;
      both_low = !s5 && !s10;
      case (state_q)
         IDLE: begin
            if (s5 && s10) begin
               state_d = REJECT;
               cnt_d   = '0;
            end else if (s5 || s10) begin
               state_d = QUALIFY;
               cnt_d   = CW'(1);
               is10_d  = s10;
            end
         end
         QUALIFY: begin
            if (oth) begin
               state_d = REJECT;
               cnt_d   = '0;
            end else if (!lat) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               // Qualification cycle: the only point where inhibit is looked at.
               cnt_d = '0;
               hi_d  = '0;
               if (bus.inhibit) begin
                  state_d = REJECT;
               end else begin
                  state_d = WAIT_RELEASE;
                  emit    = 1'b1;
               end
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         WAIT_RELEASE: begin
            if (both_low) begin
               if (cnt_q == DebLast) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end else begin
               cnt_d = '0;
               if (hi_q == JamLast) begin
                  state_d = JAM;
               end else begin
                  hi_d = sat_inc(hi_q);
               end
            end
         end
         REJECT: begin
            if (cnt_q == RejLast) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
               hi_d    = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         JAM: begin
            if (!both_low) begin
               cnt_d = '0;
            end else if (cnt_q == DebLast) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered alongside the state they describe.
   always_comb begin
      coin_d   = emit ? (is10_q ? COIN_10 : COIN_5) : COIN_NONE;
      reject_d = (state_d == REJECT);
      jam_d    = (state_d == JAM);
      acc_d    = acc_q + {7'd0, emit};
   end

   assign bus.coin         = coin_q;
   assign bus.reject_gate  = reject_q;
   assign bus.jam          = jam_q;
   assign bus.accepted_cnt = acc_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench: stimulus queues expected coin/reject/jam events with cycle stamps,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_coin_acceptor;

   localparam int EV_COIN = 0;
   localparam int EV_REJ  = 1;
   localparam int EV_JUP  = 2;
   localparam int EV_JDN  = 3;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];

   bit rej_prev = 1'b0;
   bit jam_prev = 1'b0;
   int rej_start = 0;
   int rej_len = 0;

   coin_acceptor_if bus ();

   coin_acceptor #(
      .DEB_CYCLES(4),
      .JAM_CYCLES(64),
      .REJECT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int k, input int v, input int c);
      ev_t e;
      e.kind = k;
      e.val  = v;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic seen(input int k, input int v, input int c);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, want none", k, v, c);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v || e.cyc != c) begin
            n_fail++;
            $display("FAIL event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                     k, v, c, e.kind, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: invariants every cycle, events as they appear.
   always @(negedge clk) begin
      n_cmp++;
      if (bus.coin == 2'b11 || (bus.coin != 2'b00 && bus.reject_gate)) begin
         n_fail++;
         $display("FAIL invariant: got coin=%0d reject=%0d, want coin!=3 and not both", bus.coin,
                  bus.reject_gate);
      end
      if (bus.coin != 2'b00) seen(EV_COIN, int'(bus.coin), cyc);
      if (bus.reject_gate && !rej_prev) begin
         rej_start = cyc;
         rej_len   = 1;
      end else if (bus.reject_gate) begin
         rej_len++;
      end else if (rej_prev) begin
         seen(EV_REJ, rej_len, rej_start);
      end
      if (bus.jam && !jam_prev) seen(EV_JUP, 1, cyc);
      if (!bus.jam && jam_prev) seen(EV_JDN, 0, cyc);
      rej_prev = bus.reject_gate;
      jam_prev = bus.jam;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Coin appears 6 cycles after the raw sensor is driven (2 sync + 4 debounce).
   task automatic coin_pulse(input bit is10, input int hold, input int gap);
      push(EV_COIN, is10 ? 2 : 1, cyc + 6);
      if (is10) bus.sense10_raw = 1'b1;
      else bus.sense5_raw = 1'b1;
      tick(hold);
      bus.sense5_raw  = 1'b0;
      bus.sense10_raw = 1'b0;
      tick(gap);
   endtask

   initial begin
      int t0;
      bus.sense5_raw  = 1'b0;
      bus.sense10_raw = 1'b0;
      bus.inhibit     = 1'b0;
      rst = 1'b1;
      tick(3);
      check("reset_coin", int'(bus.coin), 0);
      check("reset_reject", int'(bus.reject_gate), 0);
      check("reset_jam", int'(bus.jam), 0);
      check("reset_cnt", int'(bus.accepted_cnt), 0);
      rst = 1'b0;
      tick(2);

      // Long 5 coin
      coin_pulse(1'b0, 20, 12);
      check("cnt_after_5", int'(bus.accepted_cnt), 1);

      // 3-cycle glitch on the 10 sensor
      bus.sense10_raw = 1'b1;
      tick(3);
      bus.sense10_raw = 1'b0;
      tick(12);
      check("cnt_after_glitch", int'(bus.accepted_cnt), 1);

      // Simultaneous sensors, then a clean 10 coin
      push(EV_REJ, 8, cyc + 3);
      bus.sense5_raw  = 1'b1;
      bus.sense10_raw = 1'b1;
      tick(4);
      bus.sense5_raw  = 1'b0;
      bus.sense10_raw = 1'b0;
      tick(16);
      coin_pulse(1'b1, 10, 12);
      check("cnt_after_10", int'(bus.accepted_cnt), 2);

      // Inhibit across qualification rejects, then the same coin is accepted
      bus.inhibit = 1'b1;
      push(EV_REJ, 8, cyc + 6);
      bus.sense5_raw = 1'b1;
      tick(10);
      bus.sense5_raw = 1'b0;
      bus.inhibit    = 1'b0;
      tick(15);
      check("cnt_after_inhibit", int'(bus.accepted_cnt), 2);
      coin_pulse(1'b0, 10, 12);
      check("cnt_after_uninhibit", int'(bus.accepted_cnt), 3);

      // Inhibit toggled away from the qualification cycle is ignored
      bus.inhibit = 1'b1;
      push(EV_COIN, 1, cyc + 6);
      bus.sense5_raw = 1'b1;
      tick(3);
      bus.inhibit = 1'b0;
      tick(4);
      bus.inhibit = 1'b1;
      tick(3);
      bus.sense5_raw = 1'b0;
      bus.inhibit    = 1'b0;
      tick(12);
      check("cnt_after_toggle", int'(bus.accepted_cnt), 4);

      // Stuck 5 coin: jam 64 cycles after qualification, clears 4 low cycles after release
      t0 = cyc;
      push(EV_COIN, 1, t0 + 6);
      push(EV_JUP, 1, t0 + 70);
      push(EV_JDN, 0, t0 + 106);
      bus.sense5_raw = 1'b1;
      tick(100);
      bus.sense5_raw = 1'b0;
      tick(14);
      check("cnt_after_jam", int'(bus.accepted_cnt), 5);
      check("jam_cleared", int'(bus.jam), 0);

      // Counter wrap
      for (int i = 0; i < 250; i++) coin_pulse(i[0], 6, 10);
      check("cnt_255", int'(bus.accepted_cnt), 255);
      coin_pulse(1'b1, 6, 10);
      check("cnt_wrap", int'(bus.accepted_cnt), 0);

      // Reset mid-QUALIFY aborts; a still-high sensor re-qualifies from IDLE
      t0 = cyc;
      push(EV_COIN, 1, t0 + 11);
      bus.sense5_raw = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(1);
      check("rst_coin", int'(bus.coin), 0);
      check("rst_reject", int'(bus.reject_gate), 0);
      check("rst_jam", int'(bus.jam), 0);
      check("rst_cnt", int'(bus.accepted_cnt), 0);
      rst = 1'b0;
      tick(15);
      bus.sense5_raw = 1'b0;
      tick(12);
      check("cnt_after_rst", int'(bus.accepted_cnt), 1);

      check("events_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that turns the raw, asynchronous, bouncy coin-slot sensors into the clean 2-bit coin code consumed by the vending-machine FSM. It synchronises both sensors, debounces them and classifies each coin as 5 or 10. It emits exactly one single-cycle code per accepted coin and drives the reject gate for invalid, simultaneous or inhibited coins. It also flags jams and counts accepted coins.

Parameters:
DEB_CYCLES, 4, consecutive synchronised cycles a sensor must be stable to qualify a rise or a release (>=2)
JAM_CYCLES, 64, maximum cycles a sensor may stay high after qualification before a jam is declared (> DEB_CYCLES)
REJECT_CYCLES, 8, cycles reject_gate is held open per rejection (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sense5_raw  in  1  async sensor, high while a 5-unit coin passes
sense10_raw  in  1  async sensor, high while a 10-unit coin passes
inhibit  in  1  sync; high = downstream busy dispensing, so qualified coins are rejected
coin  out  2  01 = 5, 10 = 10, 00 = none; never 11; registered
reject_gate  out  1  registered; high opens the return chute
jam  out  1  registered; high while in JAM
accepted_cnt  out  8  count of coins emitted, wraps 255->0

Behaviour:
- Reset (clk, rst synchronous active-high): coin=00, reject_gate=0, jam=0, accepted_cnt=0, state=IDLE, counters=0, synchroniser flops=0. rst mid-coin aborts with no output; a sensor still high after reset is re-qualified from IDLE.
- Sync: two flops per sensor, giving s5 and s10. The FSM uses only synchronised values.
- Common counter cnt, width $clog2(max(JAM_CYCLES,REJECT_CYCLES)+1); saturating, never wraps.
- States:
  IDLE: exactly one of s5/s10 high -> latch type, cnt=1, go QUALIFY. Both high -> cnt=0, go REJECT. Neither high -> stay.
  QUALIFY: latched sensor high and other low -> cnt++. Latched sensor low before qualification -> IDLE, no output (glitch). Other sensor high -> REJECT. When cnt==DEB_CYCLES-1 and still valid: if inhibit=0, coin<=code for one cycle, accepted_cnt++, go WAIT_RELEASE; if inhibit=1, go REJECT, no code.
  WAIT_RELEASE: cnt counts consecutive cycles with both sensors low; go IDLE at DEB_CYCLES. A separate high-time counter reaching JAM_CYCLES -> JAM.
  REJECT: reject_gate=1 for exactly REJECT_CYCLES cycles, then WAIT_RELEASE.
  JAM: jam=1. Exit to IDLE after both sensors are low for DEB_CYCLES consecutive cycles; jam drops on exit.
- Latency: coin is asserted exactly DEB_CYCLES+2 cycles after the first edge sampling the raw sensor high, for exactly 1 cycle. The next coin code is impossible until release is debounced.
- coin is 00 in every cycle other than the single acceptance cycle. coin and reject_gate are never simultaneously active.
- inhibit is sampled only at the qualification cycle; toggling it elsewhere has no effect.

Decomposition:
- Package coin_pkg: coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10; enum typedef acc_state_t {IDLE, QUALIFY, WAIT_RELEASE, REJECT, JAM}. The vending FSM reuses the same coin constants.
- One sub-module, sync2 (1-bit two-flop synchroniser), instantiated once per sensor.

Test Plan:
- DEB_CYCLES=4: sense5_raw high 20 cycles, then low -> coin=01 at cycle 6 only, accepted_cnt=1, reject_gate never high.
- sense10_raw high for 3 cycles (glitch) -> coin stays 00, state returns to IDLE, accepted_cnt unchanged.
- Both raws rise on the same edge -> reject_gate high for exactly 8 cycles, coin stays 00; after 4 low cycles a fresh sense10 gives coin=10.
- inhibit=1 across the qualification cycle of a 5 coin -> no coin, reject_gate 8 cycles; repeat with inhibit=0 -> coin=01.
- sense5_raw held high 100 cycles -> coin=01 once, jam=1 from cycle JAM_CYCLES after qualification; release -> jam=0 after 4 low cycles.
- 256 valid coins -> accepted_cnt wraps to 0. rst asserted during QUALIFY -> no coin pulse, all outputs 0 next cycle.
